gen_debug_mux_readout_ctrl: RTL and testbench

Sequencer that drives the selector of the multicycle debug data mux and streams one complete input debug bus out as a burst of output-width words. On each accepted request it walks the mux selector over every slice of the requested bus. For each slice it waits out the mux's register and multicycle settling time, captures the mux output, and presents it on a valid/ready stream. It sits between the debug register/readout agent and the multicycle debug data mux.

---
 rtl/gen_debug_mux_pkg.sv | 30 +++
 rtl/gen_debug_settle_timer.sv | 29 ++
 rtl/gen_debug_mux_readout_ctrl.sv | 161 ++++++++++++++++
 tb/tb_gen_debug_mux_readout_ctrl.sv | 484 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gen_debug_mux_pkg.sv
// Shared types and width helpers for the debug data mux and its readout sequencer.
// The mux and the sequencer both size their selector with these functions, so the two stay aligned.
package gen_debug_mux_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StSettle  = 2'd1,
        StPresent = 2'd2
    } readout_state_e;

    function automatic int unsigned f_slices_per_bus(input int unsigned in_w,
                                                     input int unsigned out_w);
        return (in_w + out_w - 1) / out_w;
    endfunction

    function automatic int unsigned f_data_sel_options(input int unsigned num,
                                                       input int unsigned in_w,
                                                       input int unsigned out_w);
        return num * f_slices_per_bus(in_w, out_w);
    endfunction

    function automatic int unsigned f_data_sel_width(input int unsigned num,
                                                     input int unsigned in_w,
                                                     input int unsigned out_w);
        int unsigned opts;
        opts = f_data_sel_options(num, in_w, out_w);
        return (opts > 1) ? $clog2(opts) : 1;
    endfunction

endpackage

// File: rtl/gen_debug_settle_timer.sv
// Loadable down-counter that measures the mux select-to-output settling time.
// A load presets MC_CYCLES+2; done is asserted while the count sits at zero.
module gen_debug_settle_timer #(
    parameter int unsigned  MC_CYCLES = 2,
    localparam int unsigned CNT_WIDTH = $clog2(MC_CYCLES + 3)
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_done
);

    logic [CNT_WIDTH-1:0] r_count;

    // Count register: load has priority, otherwise decrement until zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= CNT_WIDTH'(MC_CYCLES + 2);
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - CNT_WIDTH'(1);
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/gen_debug_mux_readout_ctrl.sv
// Readout sequencer for the multicycle debug data mux: walks the selector over every slice of the
// requested bus, waits out the mux latency, and streams each captured word on a valid/ready port.
// Optional macro GEN_DEBUG_MUX_READOUT_ABORT_EN adds a synchronous i_abort input.
module gen_debug_mux_readout_ctrl
    import gen_debug_mux_pkg::*;
#(
    parameter int unsigned  IN_DATA_BUS_WIDTH    = 100,
    parameter int unsigned  NUM_OF_IN_DATA_BUSES = 3,
    parameter int unsigned  OUT_DATA_BUS_WIDTH   = 32,
    parameter int unsigned  MC_CYCLES            = 2,
    localparam int unsigned SLICES_PER_BUS = f_slices_per_bus(IN_DATA_BUS_WIDTH,
                                                              OUT_DATA_BUS_WIDTH),
    localparam int unsigned DATA_SEL_WIDTH = f_data_sel_width(NUM_OF_IN_DATA_BUSES,
                                                              IN_DATA_BUS_WIDTH,
                                                              OUT_DATA_BUS_WIDTH),
    localparam int unsigned BUS_IDX_WIDTH  = (NUM_OF_IN_DATA_BUSES > 1) ?
                                             $clog2(NUM_OF_IN_DATA_BUSES) : 1,
    localparam int unsigned SLICE_WIDTH    = (SLICES_PER_BUS > 1) ? $clog2(SLICES_PER_BUS) : 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
`ifdef GEN_DEBUG_MUX_READOUT_ABORT_EN
    input  logic                          i_abort,
`endif
    input  logic                          i_req_valid,
    output logic                          o_req_ready,
    input  logic [BUS_IDX_WIDTH-1:0]      i_req_bus_idx,
    output logic [DATA_SEL_WIDTH-1:0]     o_mux_data_sel,
    input  logic [OUT_DATA_BUS_WIDTH-1:0] i_mux_out_data,
    output logic                          o_rd_valid,
    input  logic                          i_rd_ready,
    output logic [OUT_DATA_BUS_WIDTH-1:0] o_rd_data,
    output logic [SLICE_WIDTH-1:0]        o_rd_slice,
    output logic                          o_rd_last,
    output logic                          o_busy,
    output logic                          o_err_bad_idx
);

    readout_state_e                r_state, w_state_next;
    logic [DATA_SEL_WIDTH-1:0]     r_sel, w_sel_next;
    logic [SLICE_WIDTH-1:0]        r_slice, w_slice_next;
    logic                          r_rd_valid, w_rd_valid_next;
    logic [OUT_DATA_BUS_WIDTH-1:0] r_rd_data, w_rd_data_next;
    logic [SLICE_WIDTH-1:0]        r_rd_slice, w_rd_slice_next;
    logic                          r_rd_last, w_rd_last_next;
    logic                          r_err, w_err_next;
    logic                          w_tmr_load, w_tmr_en, w_tmr_done;
    logic                          w_abort, w_bad_idx;
    logic [DATA_SEL_WIDTH-1:0]     w_sel_base;

`ifdef GEN_DEBUG_MUX_READOUT_ABORT_EN
    assign w_abort = i_abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_bad_idx  = (32'(i_req_bus_idx) >= NUM_OF_IN_DATA_BUSES);
    assign w_sel_base = DATA_SEL_WIDTH'(32'(i_req_bus_idx) * SLICES_PER_BUS);

    gen_debug_settle_timer #(
        .MC_CYCLES (MC_CYCLES)
    ) u_settle_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (w_tmr_load),
        .i_en    (w_tmr_en),
        .o_done  (w_tmr_done)
    );

    // Next-state, selector stepping and word capture.
    always_comb begin
        w_state_next    = r_state;
        w_sel_next      = r_sel;
        w_slice_next    = r_slice;
        w_rd_valid_next = r_rd_valid;
        w_rd_data_next  = r_rd_data;
        w_rd_slice_next = r_rd_slice;
        w_rd_last_next  = r_rd_last;
        w_err_next      = 1'b0;
        w_tmr_load      = 1'b0;
        w_tmr_en        = 1'b0;
        if (w_abort) begin
            // Selector and captured data are deliberately left as they were.
            w_state_next    = StIdle;
            w_rd_valid_next = 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_req_valid) begin
                        if (w_bad_idx) begin
                            w_err_next = 1'b1;
                        end else begin
                            w_sel_next   = w_sel_base;
                            w_slice_next = '0;
                            w_tmr_load   = 1'b1;
                            w_state_next = StSettle;
                        end
                    end
                end
                StSettle: begin
                    if (w_tmr_done) begin
                        w_rd_data_next  = i_mux_out_data;
                        w_rd_valid_next = 1'b1;
                        w_rd_slice_next = r_slice;
                        w_rd_last_next  = (r_slice == SLICE_WIDTH'(SLICES_PER_BUS - 1));
                        w_state_next    = StPresent;
                    end else begin
                        w_tmr_en = 1'b1;
                    end
                end
                StPresent: begin
                    if (i_rd_ready) begin
                        w_rd_valid_next = 1'b0;
                        if (r_rd_last) begin
                            w_state_next = StIdle;
                        end else begin
                            w_sel_next   = r_sel + DATA_SEL_WIDTH'(1);
                            w_slice_next = r_slice + SLICE_WIDTH'(1);
                            w_tmr_load   = 1'b1;
                            w_state_next = StSettle;
                        end
                    end
                end
                default: w_state_next = StIdle;
            endcase
        end
    end

    // State and output registers; reset abandons any burst in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_sel      <= '0;
            r_slice    <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_rd_slice <= '0;
            r_rd_last  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_sel      <= w_sel_next;
            r_slice    <= w_slice_next;
            r_rd_valid <= w_rd_valid_next;
            r_rd_data  <= w_rd_data_next;
            r_rd_slice <= w_rd_slice_next;
            r_rd_last  <= w_rd_last_next;
            r_err      <= w_err_next;
        end
    end

    assign o_req_ready    = (r_state == StIdle);
    assign o_busy         = (r_state != StIdle);
    assign o_mux_data_sel = r_sel;
    assign o_rd_valid     = r_rd_valid;
    assign o_rd_data      = r_rd_data;
    assign o_rd_slice     = r_rd_slice;
    assign o_rd_last      = r_rd_last;
    assign o_err_bad_idx  = r_err;

endmodule

// File: tb/tb_gen_debug_mux_readout_ctrl.sv
// Bench for gen_debug_mux_readout_ctrl: default instance (100/3/32, MC=2) plus a 64/3/32 MC=0
// instance. Each has a behavioural mux whose output follows the selector only after the full
// select-to-output latency. Abort scenario is built when GEN_DEBUG_MUX_READOUT_ABORT_EN is defined.
module tb_gen_debug_mux_readout_ctrl;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  slice;
        logic        last;
        logic [3:0]  sel;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Default-parameter instance signals
    logic        req_valid, req_ready, rd_valid, rd_ready, rd_last, busy, err;
    logic [1:0]  req_bus_idx, rd_slice;
    logic [3:0]  sel;
    logic [31:0] mux_out, rd_data;

    // MC_CYCLES=0, IN=64 instance signals
    logic        req_valid2, req_ready2, rd_valid2, rd_ready2, rd_last2, busy2, err2;
    logic [1:0]  req_bus_idx2;
    logic [0:0]  rd_slice2;
    logic [2:0]  sel2;
    logic [31:0] mux_out2, rd_data2;

`ifdef GEN_DEBUG_MUX_READOUT_ABORT_EN
    logic abort, abort2;
`endif

    logic [99:0] bus_data  [3];
    logic [63:0] bus2_data [3];
    logic [3:0]  sel_pipe  [4];
    logic [2:0]  sel2_pipe [2];

    exp_t sb[$];
    exp_t sb2[$];
    int   n_vec = 0;
    int   n_err = 0;

    gen_debug_mux_readout_ctrl dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
`ifdef GEN_DEBUG_MUX_READOUT_ABORT_EN
        .i_abort        (abort),
`endif
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_bus_idx  (req_bus_idx),
        .o_mux_data_sel (sel),
        .i_mux_out_data (mux_out),
        .o_rd_valid     (rd_valid),
        .i_rd_ready     (rd_ready),
        .o_rd_data      (rd_data),
        .o_rd_slice     (rd_slice),
        .o_rd_last      (rd_last),
        .o_busy         (busy),
        .o_err_bad_idx  (err)
    );

    gen_debug_mux_readout_ctrl #(
        .IN_DATA_BUS_WIDTH    (64),
        .NUM_OF_IN_DATA_BUSES (3),
        .OUT_DATA_BUS_WIDTH   (32),
        .MC_CYCLES            (0)
    ) dut2 (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
`ifdef GEN_DEBUG_MUX_READOUT_ABORT_EN
        .i_abort        (abort2),
`endif
        .i_req_valid    (req_valid2),
        .o_req_ready    (req_ready2),
        .i_req_bus_idx  (req_bus_idx2),
        .o_mux_data_sel (sel2),
        .i_mux_out_data (mux_out2),
        .o_rd_valid     (rd_valid2),
        .i_rd_ready     (rd_ready2),
        .o_rd_data      (rd_data2),
        .o_rd_slice     (rd_slice2),
        .o_rd_last      (rd_last2),
        .o_busy         (busy2),
        .o_err_bad_idx  (err2)
    );

    // Mux models: output reflects a selector only after MC_CYCLES+2 register stages.
    function automatic logic [31:0] mux_slice(input logic [3:0] s);
        logic [127:0] padded;
        int b, k;
        if (s >= 4'd12) return {28'hBAD0BAD, s};
        b = int'(s) / 4;
        k = int'(s) % 4;
        padded = {28'd0, bus_data[b]};
        return padded[k*32 +: 32];
    endfunction

    function automatic logic [31:0] mux2_slice(input logic [2:0] s);
        int b, k;
        if (s >= 3'd6) return {29'h1BAD0BAD, s};
        b = int'(s) / 2;
        k = int'(s) % 2;
        return bus2_data[b][k*32 +: 32];
    endfunction

    always @(posedge clk) begin
        sel_pipe[0] <= sel;
        for (int i = 1; i < 4; i++) sel_pipe[i] <= sel_pipe[i-1];
        sel2_pipe[0] <= sel2;
        sel2_pipe[1] <= sel2_pipe[0];
    end

    assign mux_out  = mux_slice(sel_pipe[3]);
    assign mux_out2 = mux2_slice(sel2_pipe[1]);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected words for one burst of the default instance.
    task automatic push_bus(input int b);
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            e.data  = 32'(bus_data[b] >> (32 * k));
            e.slice = 2'(k);
            e.last  = (k == 3);
            e.sel   = 4'(4 * b + k);
            sb.push_back(e);
        end
    endtask

    // Consume n words with rd_ready high; each must follow its select change by 5 cycles.
    task automatic stream_words(input int n);
        exp_t e;
        int lat;
        for (int w = 0; w < n; w++) begin
            lat = 0;
            while (rd_valid !== 1'b1 && lat < 50) begin
                tick();
                lat++;
            end
            n_vec++;
            if (lat != 5) begin
                n_err++;
                $display("FAIL word_latency: got %0d cycles, want 5", lat);
            end
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL scoreboard: word seen with nothing expected");
                return;
            end
            e = sb.pop_front();
            n_vec++;
            if ({rd_data, rd_slice, rd_last} !== {e.data, e.slice, e.last}) begin
                n_err++;
                $display("FAIL word: got data=%h slice=%0d last=%b, want data=%h slice=%0d last=%b",
                         rd_data, rd_slice, rd_last, e.data, e.slice, e.last);
            end
            n_vec++;
            if (sel !== e.sel) begin
                n_err++;
                $display("FAIL mux_sel: got %0d, want %0d", sel, e.sel);
            end
            if (e.last) begin
                n_vec++;
                if (rd_data[31:4] !== 28'd0) begin
                    n_err++;
                    $display("FAIL pad_bits: got %h, want 0", rd_data[31:4]);
                end
                req_valid = 1'b0;
            end
            n_vec++;
            if (err !== 1'b0) begin
                n_err++;
                $display("FAIL err_in_burst: got %b, want 0", err);
            end
            tick();
            n_vec++;
            if (rd_valid !== 1'b0) begin
                n_err++;
                $display("FAIL valid_drop: got %b, want 0", rd_valid);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_vec++;
        if ({sel, rd_valid, rd_data, rd_slice, rd_last, busy, err} !== 43'd0 ||
            req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset: got sel=%0d v=%b d=%h s=%0d l=%b busy=%b err=%b rdy=%b, want 0s/rdy=1",
                     sel, rd_valid, rd_data, rd_slice, rd_last, busy, err, req_ready);
        end
        n_vec++;
        if ({sel2, rd_valid2, rd_data2, rd_slice2, rd_last2, busy2, err2} !== 40'd0 ||
            req_ready2 !== 1'b1) begin
            n_err++;
            $display("FAIL reset2: got sel=%0d v=%b d=%h busy=%b rdy=%b, want 0s/rdy=1",
                     sel2, rd_valid2, rd_data2, busy2, req_ready2);
        end
        #9;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_burst_bus1();
        push_bus(1);
        rd_ready    = 1'b1;
        req_valid   = 1'b1;
        req_bus_idx = 2'd1;
        tick();
        req_valid = 1'b0;
        n_vec++;
        if (sel !== 4'd4 || busy !== 1'b1 || req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL accept: got sel=%0d busy=%b rdy=%b, want 4/1/0", sel, busy, req_ready);
        end
        stream_words(4);
        n_vec++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL burst_end: got rdy=%b busy=%b, want 1/0", req_ready, busy);
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int lat;
        push_bus(2);
        rd_ready    = 1'b0;
        req_valid   = 1'b1;
        req_bus_idx = 2'd2;
        tick();
        req_valid = 1'b0;
        lat = 0;
        while (rd_valid !== 1'b1 && lat < 50) begin
            tick();
            lat++;
        end
        n_vec++;
        if (lat != 5) begin
            n_err++;
            $display("FAIL bp_latency: got %0d cycles, want 5", lat);
        end
        e = sb.pop_front();
        for (int i = 0; i < 10; i++) begin
            n_vec++;
            if (rd_valid !== 1'b1 || rd_data !== e.data || rd_slice !== 2'd0 || sel !== 4'd8) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got v=%b d=%h s=%0d sel=%0d, want 1/%h/0/8",
                         i, rd_valid, rd_data, rd_slice, sel, e.data);
            end
            tick();
        end
        rd_ready = 1'b1;
        n_vec++;
        if ({rd_data, rd_slice, rd_last} !== {e.data, e.slice, e.last}) begin
            n_err++;
            $display("FAIL bp_word: got %h/%0d/%b, want %h/%0d/%b",
                     rd_data, rd_slice, rd_last, e.data, e.slice, e.last);
        end
        tick();
        stream_words(3);
        n_vec++;
        if (req_ready !== 1'b1 || sel !== 4'd11) begin
            n_err++;
            $display("FAIL bp_end: got rdy=%b sel=%0d, want 1/11", req_ready, sel);
        end
    endtask

    task automatic test_bad_idx();
        req_valid   = 1'b1;
        req_bus_idx = 2'd3;
        tick();
        req_valid = 1'b0;
        n_vec++;
        if (err !== 1'b1 || busy !== 1'b0 || req_ready !== 1'b1 || sel !== 4'd11) begin
            n_err++;
            $display("FAIL bad_idx: got err=%b busy=%b rdy=%b sel=%0d, want 1/0/1/11",
                     err, busy, req_ready, sel);
        end
        tick();
        n_vec++;
        if (err !== 1'b0 || busy !== 1'b0 || sel !== 4'd11) begin
            n_err++;
            $display("FAIL bad_idx_pulse: got err=%b busy=%b sel=%0d, want 0/0/11", err, busy, sel);
        end
    endtask

    // A bad request held during a burst must be ignored while busy.
    task automatic test_ignore_busy();
        push_bus(0);
        rd_ready    = 1'b1;
        req_valid   = 1'b1;
        req_bus_idx = 2'd0;
        tick();
        req_bus_idx = 2'd3;
        stream_words(4);
        n_vec++;
        if (req_ready !== 1'b1 || sel !== 4'd3 || err !== 1'b0) begin
            n_err++;
            $display("FAIL ignore_busy_end: got rdy=%b sel=%0d err=%b, want 1/3/0", req_ready, sel, err);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        push_bus(0);
        rd_ready    = 1'b1;
        req_valid   = 1'b1;
        req_bus_idx = 2'd0;
        tick();
        req_valid = 1'b0;
        stream_words(2);
        lat = 0;
        while (rd_valid !== 1'b1 && lat < 50) begin
            tick();
            lat++;
        end
        n_vec++;
        if (rd_slice !== 2'd2 || sel !== 4'd2) begin
            n_err++;
            $display("FAIL mid_slice: got slice=%0d sel=%0d, want 2/2", rd_slice, sel);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({sel, rd_valid, rd_data, rd_slice, rd_last, busy, err} !== 43'd0 ||
            req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL mid_reset: got sel=%0d v=%b d=%h s=%0d l=%b busy=%b, want 0s",
                     sel, rd_valid, rd_data, rd_slice, rd_last, busy);
        end
        sb.delete();
        #3;
        rst_n = 1'b1;
        tick();
        n_vec++;
        if (busy !== 1'b0 || rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL no_resume: got busy=%b v=%b, want 0/0", busy, rd_valid);
        end
        push_bus(0);
        req_valid   = 1'b1;
        req_bus_idx = 2'd0;
        tick();
        req_valid = 1'b0;
        n_vec++;
        if (sel !== 4'd0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL restart: got sel=%0d busy=%b, want 0/1", sel, busy);
        end
        stream_words(4);
    endtask

    task automatic test_mc0();
        exp_t e;
        int lat;
        for (int k = 0; k < 2; k++) begin
            e.data  = 32'(bus2_data[1] >> (32 * k));
            e.slice = 2'(k);
            e.last  = (k == 1);
            e.sel   = 4'(2 + k);
            sb2.push_back(e);
        end
        rd_ready2    = 1'b1;
        req_valid2   = 1'b1;
        req_bus_idx2 = 2'd1;
        tick();
        req_valid2 = 1'b0;
        for (int w = 0; w < 2; w++) begin
            lat = 0;
            while (rd_valid2 !== 1'b1 && lat < 50) begin
                tick();
                lat++;
            end
            n_vec++;
            if (lat != 3) begin
                n_err++;
                $display("FAIL mc0_latency: got %0d cycles, want 3", lat);
            end
            e = sb2.pop_front();
            n_vec++;
            if ({rd_data2, rd_slice2, rd_last2, sel2} !==
                {e.data, e.slice[0], e.last, e.sel[2:0]}) begin
                n_err++;
                $display("FAIL mc0_word: got %h/%0d/%b sel=%0d, want %h/%0d/%b sel=%0d",
                         rd_data2, rd_slice2, rd_last2, sel2, e.data, e.slice, e.last, e.sel);
            end
            tick();
        end
        n_vec++;
        if (req_ready2 !== 1'b1 || rd_valid2 !== 1'b0) begin
            n_err++;
            $display("FAIL mc0_end: got rdy=%b v=%b, want 1/0", req_ready2, rd_valid2);
        end
    endtask

`ifdef GEN_DEBUG_MUX_READOUT_ABORT_EN
    task automatic test_abort();
        int lat;
        logic [31:0] exp_word;
        exp_word    = 32'(bus_data[1]);
        rd_ready    = 1'b0;
        req_valid   = 1'b1;
        req_bus_idx = 2'd1;
        tick();
        req_valid = 1'b0;
        lat = 0;
        while (rd_valid !== 1'b1 && lat < 50) begin
            tick();
            lat++;
        end
        n_vec++;
        if (lat != 5) begin
            n_err++;
            $display("FAIL abort_latency: got %0d, want 5", lat);
        end
        abort    = 1'b1;
        rd_ready = 1'b1;
        tick();
        abort    = 1'b0;
        rd_ready = 1'b0;
        n_vec++;
        if (rd_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 || sel !== 4'd4 ||
            rd_data !== exp_word) begin
            n_err++;
            $display("FAIL abort: got v=%b busy=%b rdy=%b sel=%0d d=%h, want 0/0/1/4/%h",
                     rd_valid, busy, req_ready, sel, rd_data, exp_word);
        end
        repeat (8) tick();
        n_vec++;
        if (sel !== 4'd4 || rd_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL abort_idle: got sel=%0d v=%b busy=%b, want 4/0/0", sel, rd_valid, busy);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] tmp;
        for (int i = 0; i < 3; i++) begin
            tmp          = {$urandom, $urandom, $urandom, $urandom};
            bus_data[i]  = tmp[99:0];
            bus2_data[i] = {$urandom, $urandom};
        end
        req_valid    = 1'b0;
        req_bus_idx  = 2'd0;
        rd_ready     = 1'b0;
        req_valid2   = 1'b0;
        req_bus_idx2 = 2'd0;
        rd_ready2    = 1'b0;
`ifdef GEN_DEBUG_MUX_READOUT_ABORT_EN
        abort  = 1'b0;
        abort2 = 1'b0;
`endif
        test_reset();
        test_burst_bus1();
        test_backpressure();
        test_bad_idx();
        test_ignore_busy();
        test_reset_mid();
        test_mc0();
`ifdef GEN_DEBUG_MUX_READOUT_ABORT_EN
        test_abort();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
